// File: rtl/move_path_checker.sv
// move_path_checker
// Validates one move on a BOARD_DIM x BOARD_DIM board. Row and column are
// handled separately, so moves cannot wrap around a board edge. Each square
// between source and target is read through a board port with one cycle of
// read latency, and the move is then checked against the capture rules.
// allow/reason stay valid from the done pulse until the next accepted start.
module move_path_checker #(
   parameter int BOARD_DIM = 8,
   parameter int LOG_DIM   = $clog2(BOARD_DIM),
   parameter int POS_W     = 2 * LOG_DIM
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [POS_W-1:0] src_pos,
   input  logic [POS_W-1:0] dst_pos,
   input  logic [3:0]       src_piece,
   output logic             rd_en,
   output logic [POS_W-1:0] rd_addr,
   input  logic [3:0]       rd_data,
   output logic             busy,
   output logic             done,
   output logic             allow,
   output logic [2:0]       reason
);

   typedef enum logic [2:0] {
      S_IDLE, S_GEOM, S_SREAD, S_SCHK, S_TREAD, S_TCHK, S_DONE
   } state_t;

   typedef enum logic [2:0] {
      R_OK          = 3'd0,
      R_EMPTY_SRC   = 3'd1,
      R_GEOMETRY    = 3'd2,
      R_BLOCKED     = 3'd3,
      R_OWN_CAPTURE = 3'd4,
      R_PAWN_TARGET = 3'd5
   } reason_t;

   typedef enum logic [2:0] {
      P_EMPTY   = 3'd0,
      P_KING    = 3'd1,
      P_QUEEN   = 3'd2,
      P_BISHOP  = 3'd3,
      P_KNIGHT  = 3'd4,
      P_ROOK    = 3'd5,
      P_PAWN    = 3'd6,
      P_INVALID = 3'd7
   } piece_t;

   localparam logic [LOG_DIM:0]   ONE            = 1;
   localparam logic [LOG_DIM:0]   TWO            = 2;
   localparam logic [LOG_DIM-1:0] STEP_POS       = 1;
   localparam logic [LOG_DIM-1:0] WHITE_PAWN_ROW = LOG_DIM'(BOARD_DIM - 2);
   localparam logic [LOG_DIM-1:0] BLACK_PAWN_ROW = 1;

   state_t             state;
   logic [LOG_DIM-1:0] srcRow, srcCol, dstRow, dstCol;
   logic [LOG_DIM-1:0] walkRow, walkCol;
   logic [3:0]         pieceReg;
   piece_t             pieceType;

   logic [LOG_DIM:0]   dr, dc, absDr, absDc, maxAbs;
   logic               drNeg, dcNeg, zeroMove, pawnFwd;
   logic [LOG_DIM-1:0] stepRow, stepCol, pawnStartRow;
   logic               emptySrc, geomOk, sliding;
   logic [LOG_DIM-1:0] firstRow, firstCol, nextRow, nextCol;
   logic               tgtOcc, tgtOwn;
   reason_t            tchkReason;

   assign pieceType = piece_t'(pieceReg[2:0]);

   // Row/column deltas, unit step direction and walker arithmetic
   always_comb begin
      dr       = {1'b0, dstRow} - {1'b0, srcRow};
      dc       = {1'b0, dstCol} - {1'b0, srcCol};
      drNeg    = dr[LOG_DIM];
      dcNeg    = dc[LOG_DIM];
      absDr    = drNeg ? (~dr + 1'b1) : dr;
      absDc    = dcNeg ? (~dc + 1'b1) : dc;
      maxAbs   = (absDr > absDc) ? absDr : absDc;
      zeroMove = (absDr == '0) && (absDc == '0);
      stepRow  = (absDr == '0) ? '0 : (drNeg ? '1 : STEP_POS);
      stepCol  = (absDc == '0) ? '0 : (dcNeg ? '1 : STEP_POS);
      firstRow = srcRow + stepRow;
      firstCol = srcCol + stepCol;
      nextRow  = walkRow + stepRow;
      nextCol  = walkCol + stepCol;
   end

   // Per-piece geometry and whether the move passes over intermediate squares
   always_comb begin
      emptySrc     = (pieceType == P_EMPTY) || (pieceType == P_INVALID);
      pawnFwd      = pieceReg[3] ? !drNeg : drNeg;
      pawnStartRow = pieceReg[3] ? BLACK_PAWN_ROW : WHITE_PAWN_ROW;
      geomOk       = 1'b0;
      sliding      = 1'b0;
      case (pieceType)
         P_KING:   geomOk = !zeroMove && (absDr <= ONE) && (absDc <= ONE);
         P_KNIGHT: geomOk = ((absDr == ONE) && (absDc == TWO)) ||
                            ((absDr == TWO) && (absDc == ONE));
         P_ROOK: begin
            geomOk  = (absDr == '0) != (absDc == '0);
            sliding = 1'b1;
         end
         P_BISHOP: begin
            geomOk  = !zeroMove && (absDr == absDc);
            sliding = 1'b1;
         end
         P_QUEEN: begin
            geomOk  = ((absDr == '0) != (absDc == '0)) ||
                      (!zeroMove && (absDr == absDc));
            sliding = 1'b1;
         end
         P_PAWN: begin
            geomOk  = pawnFwd &&
                      (((absDr == ONE) && (absDc <= ONE)) ||
                       ((absDr == TWO) && (absDc == '0) && (srcRow == pawnStartRow)));
            sliding = 1'b1;
         end
         default: geomOk = 1'b0;
      endcase
      // Only moves spanning more than one square have squares to walk
      sliding = sliding && (maxAbs > ONE);
   end

   // Target-square verdict from the board word returned by the read port
   always_comb begin
      tgtOcc     = rd_data[2:0] != 3'b000;
      tgtOwn     = tgtOcc && (rd_data[3] == pieceReg[3]);
      tchkReason = R_OK;
      if (pieceType == P_PAWN) begin
         if (absDc == '0) begin
            if (tgtOcc) tchkReason = R_PAWN_TARGET;
         end else if (!tgtOcc) begin
            tchkReason = R_PAWN_TARGET;
         end else if (tgtOwn) begin
            tchkReason = R_OWN_CAPTURE;
         end
      end else if (tgtOwn) begin
         tchkReason = R_OWN_CAPTURE;
      end
   end

   // Sequencer: one state per cycle; every output is registered on entry to its state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         srcRow   <= '0;
         srcCol   <= '0;
         dstRow   <= '0;
         dstCol   <= '0;
         walkRow  <= '0;
         walkCol  <= '0;
         pieceReg <= '0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         allow    <= 1'b0;
         reason   <= R_OK;
      end else begin
         rd_en <= 1'b0;
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  srcRow   <= src_pos[LOG_DIM-1:0];
                  srcCol   <= src_pos[POS_W-1:LOG_DIM];
                  dstRow   <= dst_pos[LOG_DIM-1:0];
                  dstCol   <= dst_pos[POS_W-1:LOG_DIM];
                  pieceReg <= src_piece;
                  busy     <= 1'b1;
                  allow    <= 1'b0;
                  reason   <= R_OK;
                  state    <= S_GEOM;
               end
            end
            S_GEOM: begin
               if (emptySrc) begin
                  reason <= R_EMPTY_SRC;
                  allow  <= 1'b0;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_DONE;
               end else if (!geomOk) begin
                  reason <= R_GEOMETRY;
                  allow  <= 1'b0;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_DONE;
               end else if (sliding) begin
                  walkRow <= firstRow;
                  walkCol <= firstCol;
                  rd_en   <= 1'b1;
                  rd_addr <= {firstCol, firstRow};
                  state   <= S_SREAD;
               end else begin
                  rd_en   <= 1'b1;
                  rd_addr <= {dstCol, dstRow};
                  state   <= S_TREAD;
               end
            end
            S_SREAD: state <= S_SCHK;
            S_SCHK: begin
               if (tgtOcc) begin
                  reason <= R_BLOCKED;
                  allow  <= 1'b0;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_DONE;
               end else begin
                  // The next square is either another intermediate or the target;
                  // in both cases it is the next address to read.
                  walkRow <= nextRow;
                  walkCol <= nextCol;
                  rd_en   <= 1'b1;
                  rd_addr <= {nextCol, nextRow};
                  if ((nextRow == dstRow) && (nextCol == dstCol)) state <= S_TREAD;
                  else                                            state <= S_SREAD;
               end
            end
            S_TREAD: state <= S_TCHK;
            S_TCHK: begin
               reason <= tchkReason;
               allow  <= (tchkReason == R_OK);
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
